// File: rtl/pkt_class_filter_pkg.sv
// Shared definitions for the packet class filter:
// FSM state codes, cfg_finish codes and software mask presets.
package pkt_class_filter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRAN    = 2'd1,
    S_DISCARD = 2'd2,
    S_RESYNC  = 2'd3
  } state_e;

  localparam logic [1:0] CFG_DISCARD = 2'b00;

  localparam logic [7:0] MASK_NMAC   = 8'h20;
  localparam logic [7:0] MASK_NON_TS = 8'hF8;
  localparam logic [7:0] MASK_ALL    = 8'hFF;

  function automatic logic head_pass(
    input logic [1:0] cfg,
    input logic       tsn,
    input logic       std_port,
    input logic       mask_bit
  );
    return (cfg != CFG_DISCARD) &&
           (tsn || std_port || mask_bit);
  endfunction

endpackage

// File: rtl/pkt_sat_cnt.sv
// Saturating statistics counter with synchronous clear;
// clear wins over a same-cycle increment.
module pkt_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pkt_class_filter.sv
// Ingress packet filter: pass/drop decided on the head beat,
// with length truncation and pass/drop statistics.
module pkt_class_filter
  import pkt_class_filter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int TSW      = 19,
  parameter int TYPE_LSB = 5,
  parameter int TYPE_W   = 3,
  parameter int MAX_LEN  = 2047,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 port_type,
  input  logic [1:0]           cfg_finish,
  input  logic [2**TYPE_W-1:0] iv_type_mask,
  input  logic [DW:0]          iv_data,
  input  logic                 i_data_wr,
  input  logic                 i_tsn_en,
  input  logic [TSW-1:0]       iv_rec_ts,
  input  logic                 i_cnt_clr,
  output logic [DW:0]          ov_data,
  output logic                 o_data_wr,
  output logic [TSW-1:0]       ov_rec_ts,
  output logic                 o_tsn_en,
  output logic                 o_pkt_valid_pulse,
  output logic                 o_pkt_drop_pulse,
  output logic                 o_trunc_pulse,
  output logic [CNT_W-1:0]     ov_pass_cnt,
  output logic [CNT_W-1:0]     ov_drop_cnt,
  output logic [1:0]           ov_state_report
);

  localparam int BW = $clog2(MAX_LEN + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_LEN);

  state_e         r_state;
  logic [BW-1:0]  r_beat;
  logic [DW:0]    r_data;
  logic           r_data_wr;
  logic [TSW-1:0] r_rec_ts;
  logic           r_tsn;
  logic           r_vp;
  logic           r_dp;
  logic           r_tr;

  logic              w_tail;
  logic [TYPE_W-1:0] w_type;
  logic              w_pass;
  logic              w_head;
  logic              w_tran;
  logic [BW-1:0]     w_beat_nxt;
  logic              w_trunc;
  logic              w_pass_inc;
  logic              w_drop_inc;

  always_comb begin
    w_tail     = iv_data[DW];
    w_type     = iv_data[TYPE_LSB +: TYPE_W];
    w_pass     = head_pass(cfg_finish, i_tsn_en,
                           port_type, iv_type_mask[w_type]);
    w_head     = (r_state == S_IDLE) && i_data_wr;
    w_tran     = (r_state == S_TRAN) && i_data_wr;
    w_beat_nxt = r_beat + 1'b1;
    w_trunc    = w_tran && !w_tail && (w_beat_nxt == MAX_B);
    w_pass_inc = (w_head && w_pass && w_tail) ||
                 (w_tran && w_tail);
    w_drop_inc = (w_head && !w_pass) || w_trunc;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_RESYNC;
      r_beat    <= '0;
      r_data    <= '0;
      r_data_wr <= 1'b0;
      r_rec_ts  <= '0;
      r_tsn     <= 1'b0;
      r_vp      <= 1'b0;
      r_dp      <= 1'b0;
      r_tr      <= 1'b0;
    end else begin
      r_data_wr <= 1'b0;
      r_data    <= '0;
      r_rec_ts  <= '0;
      r_vp      <= w_pass_inc;
      r_dp      <= w_drop_inc;
      r_tr      <= w_trunc;
      unique case (r_state)
        S_RESYNC: begin
          r_tsn <= 1'b0;
          if (!i_data_wr) r_state <= S_IDLE;
        end
        S_IDLE: begin
          r_tsn <= 1'b0;
          if (i_data_wr && w_pass) begin
            r_data_wr <= 1'b1;
            r_data    <= iv_data;
            r_rec_ts  <= iv_rec_ts;
            r_tsn     <= i_tsn_en;
            r_beat    <= BW'(1);
            if (!w_tail) r_state <= S_TRAN;
          end else if (i_data_wr && !w_tail) begin
            r_state <= S_DISCARD;
          end
        end
        S_TRAN: begin
          if (i_data_wr) begin
            r_data_wr <= 1'b1;
            r_data    <= {w_tail | w_trunc, iv_data[DW-1:0]};
            r_beat    <= w_beat_nxt;
            if (w_tail)       r_state <= S_IDLE;
            else if (w_trunc) r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (i_data_wr && w_tail) r_state <= S_IDLE;
        end
        default: r_state <= S_RESYNC;
      endcase
    end
  end

  pkt_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_inc   (w_pass_inc),
    .i_clr   (i_cnt_clr),
    .o_cnt   (ov_pass_cnt)
  );

  pkt_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_inc   (w_drop_inc),
    .i_clr   (i_cnt_clr),
    .o_cnt   (ov_drop_cnt)
  );

  assign ov_data           = r_data;
  assign o_data_wr         = r_data_wr;
  assign ov_rec_ts         = r_rec_ts;
  assign o_tsn_en          = r_tsn;
  assign o_pkt_valid_pulse = r_vp;
  assign o_pkt_drop_pulse  = r_dp;
  assign o_trunc_pulse     = r_tr;
  assign ov_state_report   = r_state;

endmodule

// File: tb/tb_pkt_class_filter.sv
// Scoreboard bench for pkt_class_filter:
// directed packets with hand-derived outcomes, MAX_LEN=8, CNT_W=4.
module tb_pkt_class_filter;

  localparam int MAXL = 8;
  localparam int CW   = 4;
  localparam int OUT_DROP  = 0;
  localparam int OUT_PASS  = 1;
  localparam int OUT_TRUNC = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        port_type = 1'b0;
  logic [1:0]  cfg_finish = 2'b00;
  logic [7:0]  iv_type_mask = 8'h00;
  logic [8:0]  iv_data = '0;
  logic        i_data_wr = 1'b0;
  logic        i_tsn_en = 1'b0;
  logic [18:0] iv_rec_ts = '0;
  logic        i_cnt_clr = 1'b0;
  logic [8:0]  ov_data;
  logic        o_data_wr;
  logic [18:0] ov_rec_ts;
  logic        o_tsn_en;
  logic        o_pkt_valid_pulse;
  logic        o_pkt_drop_pulse;
  logic        o_trunc_pulse;
  logic [CW-1:0] ov_pass_cnt;
  logic [CW-1:0] ov_drop_cnt;
  logic [1:0]  ov_state_report;

  pkt_class_filter #(
    .DW(8), .TSW(19), .TYPE_LSB(5), .TYPE_W(3),
    .MAX_LEN(MAXL), .CNT_W(CW)
  ) dut (
    .clk_sys           (clk_sys),
    .reset_n           (reset_n),
    .port_type         (port_type),
    .cfg_finish        (cfg_finish),
    .iv_type_mask      (iv_type_mask),
    .iv_data           (iv_data),
    .i_data_wr         (i_data_wr),
    .i_tsn_en          (i_tsn_en),
    .iv_rec_ts         (iv_rec_ts),
    .i_cnt_clr         (i_cnt_clr),
    .ov_data           (ov_data),
    .o_data_wr         (o_data_wr),
    .ov_rec_ts         (ov_rec_ts),
    .o_tsn_en          (o_tsn_en),
    .o_pkt_valid_pulse (o_pkt_valid_pulse),
    .o_pkt_drop_pulse  (o_pkt_drop_pulse),
    .o_trunc_pulse     (o_trunc_pulse),
    .ov_pass_cnt       (ov_pass_cnt),
    .ov_drop_cnt       (ov_drop_cnt),
    .ov_state_report   (ov_state_report)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [8:0]  data;
    logic [18:0] ts;
    logic        tsn;
    logic        vp;
    logic        tr;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int n_chk = 0;
  int n_err = 0;
  int drop_seen = 0;
  int exp_drop_pulses = 0;
  int exp_pass = 0;
  int exp_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= (2**CW - 1)) ? (2**CW - 1) : x + 1;
  endfunction

  always @(negedge clk_sys) begin
    if (o_pkt_drop_pulse) drop_seen++;
    if (o_data_wr) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_beat: got data %0h, required no beat",
                 ov_data);
      end else begin
        m_e = sb.pop_front();
        chk("beat_data", 32'(ov_data), 32'(m_e.data));
        chk("beat_ts", 32'(ov_rec_ts), 32'(m_e.ts));
        chk("beat_tsn", 32'(o_tsn_en), 32'(m_e.tsn));
        chk("beat_valid_pulse", 32'(o_pkt_valid_pulse), 32'(m_e.vp));
        chk("beat_trunc_pulse", 32'(o_trunc_pulse), 32'(m_e.tr));
      end
    end else if (o_pkt_valid_pulse || o_trunc_pulse) begin
      n_chk++;
      n_err++;
      $display("FAIL pulse_without_beat: got vp=%0b tr=%0b required 0",
               o_pkt_valid_pulse, o_trunc_pulse);
    end
  end

  // Changes config mid-packet to show it is only sampled on the head.
  task automatic send_pkt(input int n, input logic [2:0] typ,
                          input logic tsn, input logic [18:0] ts,
                          input int outc, input logic clr);
    logic [1:0] s_cfg;
    logic [7:0] s_mask;
    logic       s_pt;
    logic [8:0] d;
    logic [7:0] b;
    exp_t       e;
    s_cfg  = cfg_finish;
    s_mask = iv_type_mask;
    s_pt   = port_type;
    for (int i = 0; i < n; i++) begin
      b = 8'hA0 + 8'(i);
      d = (i == 0) ? {1'b0, typ, 5'h13} : {1'b0, b};
      d[8] = (i == n - 1);
      if (outc == OUT_PASS || (outc == OUT_TRUNC && i < MAXL)) begin
        e.data = d;
        e.ts   = (i == 0) ? ts : 19'h0;
        e.tsn  = tsn;
        e.vp   = (outc == OUT_PASS) && (i == n - 1);
        e.tr   = 1'b0;
        if (outc == OUT_TRUNC && i == MAXL - 1) begin
          e.data[8] = 1'b1;
          e.tr      = 1'b1;
        end
        sb.push_back(e);
      end
      @(posedge clk_sys); #1;
      i_data_wr = 1'b1;
      iv_data   = d;
      i_tsn_en  = (i == 0) ? tsn : 1'b0;
      iv_rec_ts = (i == 0) ? ts : 19'h7FFFF;
      i_cnt_clr = clr && (i == 0);
      if (i == 1) begin
        cfg_finish   = 2'b00;
        iv_type_mask = 8'h00;
        port_type    = ~s_pt;
      end
    end
    @(posedge clk_sys); #1;
    i_data_wr    = 1'b0;
    i_cnt_clr    = 1'b0;
    i_tsn_en     = 1'b0;
    iv_data      = '0;
    iv_rec_ts    = '0;
    cfg_finish   = s_cfg;
    iv_type_mask = s_mask;
    port_type    = s_pt;
    if (clr) begin
      exp_pass = 0;
      exp_drop = 0;
    end else if (outc == OUT_PASS) begin
      exp_pass = sat(exp_pass);
    end else begin
      exp_drop = sat(exp_drop);
    end
    if (outc != OUT_PASS) exp_drop_pulses++;
    @(posedge clk_sys); #1;
    chk("pass_cnt", 32'(ov_pass_cnt), 32'(exp_pass));
    chk("drop_cnt", 32'(ov_drop_cnt), 32'(exp_drop));
  endtask

  initial begin
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_data_wr", 32'(o_data_wr), 32'd0);
    chk("rst_data", 32'(ov_data), 32'd0);
    chk("rst_ts", 32'(ov_rec_ts), 32'd0);
    chk("rst_tsn", 32'(o_tsn_en), 32'd0);
    chk("rst_pulses", 32'({o_pkt_valid_pulse, o_pkt_drop_pulse,
                           o_trunc_pulse}), 32'd0);
    chk("rst_pass_cnt", 32'(ov_pass_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(ov_drop_cnt), 32'd0);
    chk("rst_state", 32'(ov_state_report), 32'd3);

    // Packet cut by reset: beats arrive during and after release.
    for (int k = 0; k < 3; k++) begin
      i_data_wr = 1'b1;
      iv_data   = {1'b0, 8'(8'h10 + k)};
      @(posedge clk_sys); #1;
    end
    reset_n    = 1'b1;
    port_type  = 1'b1;
    cfg_finish = 2'b01;
    for (int k = 0; k < 5; k++) begin
      i_data_wr = 1'b1;
      iv_data   = {k == 4, 8'(8'h20 + k)};
      @(posedge clk_sys); #1;
      if (k == 0) chk("resync_hold", 32'(ov_state_report), 32'd3);
    end
    i_data_wr = 1'b0;
    iv_data   = '0;
    @(posedge clk_sys); #1;
    chk("resync_exit", 32'(ov_state_report), 32'd0);
    chk("resync_pass_cnt", 32'(ov_pass_cnt), 32'd0);
    chk("resync_drop_cnt", 32'(ov_drop_cnt), 32'd0);
    send_pkt(4, 3'b000, 1'b0, 19'h00055, OUT_PASS, 1'b0);

    // Mapped port, NMAC-only mask.
    port_type    = 1'b0;
    cfg_finish   = 2'b01;
    iv_type_mask = 8'h20;
    send_pkt(3, 3'b101, 1'b0, 19'h00101, OUT_PASS, 1'b0);
    send_pkt(3, 3'b000, 1'b0, 19'h00102, OUT_DROP, 1'b0);

    // TSN: discard config wins, then TSN overrides an empty mask.
    cfg_finish = 2'b00;
    send_pkt(2, 3'b101, 1'b1, 19'h00002, OUT_DROP, 1'b0);
    cfg_finish   = 2'b10;
    iv_type_mask = 8'h00;
    send_pkt(3, 3'b000, 1'b1, 19'h00003, OUT_PASS, 1'b0);

    // Over-length packet, then a clean one.
    cfg_finish = 2'b01;
    port_type  = 1'b1;
    send_pkt(12, 3'b010, 1'b0, 19'h00004, OUT_TRUNC, 1'b0);
    chk("trunc_state", 32'(ov_state_report), 32'd0);
    send_pkt(MAXL, 3'b010, 1'b0, 19'h00005, OUT_PASS, 1'b0);

    // Single-beat packet.
    send_pkt(1, 3'b011, 1'b0, 19'h01234, OUT_PASS, 1'b0);
    chk("single_state", 32'(ov_state_report), 32'd0);

    // Saturation, then clear colliding with an increment.
    for (int k = 0; k < 20; k++)
      send_pkt(1, 3'b001, 1'b0, 19'h00006, OUT_PASS, 1'b0);
    chk("pass_sat", 32'(ov_pass_cnt), 32'hF);
    send_pkt(1, 3'b001, 1'b0, 19'h00007, OUT_PASS, 1'b1);
    send_pkt(2, 3'b001, 1'b0, 19'h00008, OUT_PASS, 1'b0);

    repeat (3) @(posedge clk_sys);
    #1;
    chk("drop_pulses", 32'(drop_seen), 32'(exp_drop_pulses));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
